// File: rtl/bram_heap_pq.sv
// Binary-heap priority queue: keys live in a sync-read RAM, root mirrored in a register.
// Enqueue sifts up, dequeue/replace sift down; o_ready is low while a sift is in flight.
module bram_heap_pq #(
  parameter int unsigned QUEUE_SIZE = 15,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MIN_MODE   = 0
) (
  input  logic                                 CLK,
  input  logic                                 RSTn,
  input  logic                                 i_wrt,
  input  logic                                 i_read,
  input  logic [DATA_WIDTH-1:0]                i_data,
  output logic                                 o_ready,
  output logic                                 o_full,
  output logic                                 o_empty,
  output logic [$clog2(QUEUE_SIZE+1)-1:0]      o_count,
  output logic [DATA_WIDTH-1:0]                o_data,
  output logic                                 o_err
);

  localparam int unsigned NW = $clog2(QUEUE_SIZE + 1);
  // Wide enough for child indices up to 2*QUEUE_SIZE
  localparam int unsigned CW = $clog2(2 * QUEUE_SIZE + 1);
  localparam int unsigned AW = $clog2(QUEUE_SIZE);

  typedef enum logic [2:0] {IDLE, UP_RD, UP_CMP, DN_RD, DN_CMP, FINISH} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [NW-1:0]         cnt_q, cnt_d;
  logic [NW-1:0]         cnt_new_q, cnt_new_d;
  logic                  ld_x_q, ld_x_d;
  logic [DATA_WIDTH-1:0] root_q, root_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [QUEUE_SIZE];
  logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;
  logic [AW-1:0]         raddr_a, raddr_b, waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;

  logic [CW-1:0]         par_c, c1_c, c2_c, best_idx;
  logic                  c1_ok, c2_ok;
  logic [DATA_WIDTH-1:0] best_val;

  function automatic logic beats(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    return (MIN_MODE != 0) ? (a < b) : (a > b);
  endfunction

  assign par_c    = (idx_q - CW'(1)) >> 1;
  assign c1_c     = (idx_q << 1) + CW'(1);
  assign c2_c     = (idx_q << 1) + CW'(2);
  assign c1_ok    = c1_c < CW'(cnt_new_q);
  assign c2_ok    = c2_c < CW'(cnt_new_q);
  // Pick the right child only if it strictly beats the left one
  assign best_idx = (c2_ok && beats(rd_b_q, rd_a_q)) ? c2_c : c1_c;
  assign best_val = (c2_ok && beats(rd_b_q, rd_a_q)) ? rd_b_q : rd_a_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    cnt_new_d = cnt_new_q;
    ld_x_d    = 1'b0;
    root_d    = root_q;
    data_d    = data_q;
    full_d    = full_q;
    empty_d   = empty_q;
    err_d     = 1'b0;
    raddr_a   = '0;
    raddr_b   = '0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;

    case (state_q)
      IDLE: begin
        if (i_wrt || i_read) begin
          if (i_read && !i_wrt && empty_q) begin
            err_d = 1'b1;
          end else if (i_wrt && !i_read && full_q) begin
            err_d = 1'b1;
          end else if (i_wrt && (!i_read || empty_q)) begin
            x_d       = i_data;
            idx_d     = CW'(cnt_q);
            cnt_new_d = cnt_q + NW'(1);
            state_d   = UP_RD;
          end else if (i_wrt) begin
            x_d       = i_data;
            idx_d     = '0;
            cnt_new_d = cnt_q;
            state_d   = DN_RD;
          end else begin
            // Last key becomes the sift-down candidate; it arrives in DN_RD
            raddr_a   = AW'(cnt_q - NW'(1));
            ld_x_d    = 1'b1;
            idx_d     = '0;
            cnt_new_d = cnt_q - NW'(1);
            state_d   = (cnt_q == NW'(1)) ? FINISH : DN_RD;
          end
        end
      end
      UP_RD: begin
        if (idx_q == '0) begin
          state_d = FINISH;
        end else begin
          raddr_a = AW'(par_c);
          state_d = UP_CMP;
        end
      end
      UP_CMP: begin
        if (beats(x_q, rd_a_q)) begin
          we      = 1'b1;
          waddr   = AW'(idx_q);
          wdata   = rd_a_q;
          idx_d   = par_c;
          state_d = UP_RD;
        end else begin
          state_d = FINISH;
        end
      end
      DN_RD: begin
        raddr_a = (c1_c < CW'(QUEUE_SIZE)) ? AW'(c1_c) : '0;
        raddr_b = (c2_c < CW'(QUEUE_SIZE)) ? AW'(c2_c) : '0;
        if (ld_x_q) x_d = rd_a_q;
        state_d = DN_CMP;
      end
      DN_CMP: begin
        if (c1_ok && beats(best_val, x_q)) begin
          we      = 1'b1;
          waddr   = AW'(idx_q);
          wdata   = best_val;
          idx_d   = best_idx;
          state_d = DN_RD;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (cnt_new_q != '0) begin
          we    = 1'b1;
          waddr = AW'(idx_q);
          wdata = x_q;
        end
        cnt_d   = cnt_new_q;
        full_d  = (cnt_new_q == NW'(QUEUE_SIZE));
        empty_d = (cnt_new_q == '0);
        data_d  = (cnt_new_q == '0) ? '0 : ((idx_q == '0) ? x_q : root_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Track every write to slot 0 so the new root is known at FINISH
    if (we && (waddr == '0)) root_d = wdata;
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      x_q       <= '0;
      cnt_q     <= '0;
      cnt_new_q <= '0;
      ld_x_q    <= 1'b0;
      root_q    <= '0;
      data_q    <= '0;
      ready_q   <= 1'b1;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      cnt_new_q <= cnt_new_d;
      ld_x_q    <= ld_x_d;
      root_q    <= root_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      err_q     <= err_d;
    end
  end

  // Key storage: one write port, two registered read ports
  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
    rd_a_q <= mem_q[raddr_a];
    rd_b_q <= mem_q[raddr_b];
  end

  assign o_ready = ready_q;
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_count = cnt_q;
  assign o_data  = data_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_bram_heap_pq.sv
// Bench for bram_heap_pq: directed vector table on a max-heap and a min-heap instance,
// reset-during-sift sequence, and random ops against a queue-based reference model.
module tb_bram_heap_pq;

  localparam int unsigned QS      = 7;
  localparam int unsigned DW      = 16;
  localparam int unsigned CNTW    = $clog2(QS + 1);
  localparam int          LAT_MAX = 2 * $clog2(QS + 1) + 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]      wrt, rd, rdy, full, empty, err;
  logic [DW-1:0]   din  [2];
  logic [DW-1:0]   dout [2];
  logic [CNTW-1:0] cnt  [2];

  bram_heap_pq #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MIN_MODE(0)) u_max (
    .CLK(clk), .RSTn(rst_n), .i_wrt(wrt[0]), .i_read(rd[0]), .i_data(din[0]),
    .o_ready(rdy[0]), .o_full(full[0]), .o_empty(empty[0]), .o_count(cnt[0]),
    .o_data(dout[0]), .o_err(err[0]));

  bram_heap_pq #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MIN_MODE(1)) u_min (
    .CLK(clk), .RSTn(rst_n), .i_wrt(wrt[1]), .i_read(rd[1]), .i_data(din[1]),
    .o_ready(rdy[1]), .o_full(full[1]), .o_empty(empty[1]), .o_count(cnt[1]),
    .o_data(dout[1]), .o_err(err[1]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: unordered bag of keys, root found by linear search
  int unsigned mq[$];
  bit          mmin;

  function automatic int best_pos();
    int b = 0;
    for (int i = 1; i < mq.size(); i++)
      if (mmin ? (mq[i] < mq[b]) : (mq[i] > mq[b])) b = i;
    return b;
  endfunction

  function automatic int unsigned model_root();
    return (mq.size() == 0) ? 0 : mq[best_pos()];
  endfunction

  // Issue one request at a negedge; returns at the first negedge with o_ready=1
  task automatic run_op(input int s, input logic w, input logic r, input logic [DW-1:0] d,
                        input bit poke, output logic got_err, output int lat,
                        output logic dropped, output logic held);
    logic [DW-1:0]   pre_d;
    logic [CNTW-1:0] pre_c;
    pre_d = dout[s];
    pre_c = cnt[s];
    wrt[s] = w; rd[s] = r; din[s] = d;
    @(negedge clk);
    wrt[s] = 1'b0; rd[s] = 1'b0;
    got_err = err[s];
    dropped = !rdy[s];
    held    = 1'b1;
    lat     = 1;
    while (!rdy[s] && lat < 64) begin
      if (dout[s] != pre_d || cnt[s] != pre_c) held = 1'b0;
      wrt[s] = poke; din[s] = 16'd999;
      @(negedge clk);
      lat++;
    end
    wrt[s] = 1'b0;
  endtask

  task automatic check_op(input string name, input int s, input logic e_err,
                          input int unsigned e_data, input int unsigned e_cnt,
                          input logic g_err, input int lat, input logic dropped, input logic held);
    chk({name, " err"},   32'(g_err),    32'(e_err));
    chk({name, " data"},  32'(dout[s]),  e_data);
    chk({name, " count"}, 32'(cnt[s]),   e_cnt);
    chk({name, " full"},  32'(full[s]),  32'(e_cnt == QS));
    chk({name, " empty"}, 32'(empty[s]), 32'(e_cnt == 0));
    chk({name, " ready"}, 32'(rdy[s]),   1);
    if (e_err) begin
      chk({name, " ready_dropped"}, 32'(dropped), 0);
    end else begin
      chk({name, " held_until_finish"}, 32'(held), 1);
      n_checks++;
      if (lat > LAT_MAX) begin
        n_errors++;
        $display("FAIL %s latency: got %0d cycles limit %0d", name, lat, LAT_MAX);
      end
    end
  endtask

  typedef struct {
    string        name;
    int           s;
    logic         w;
    logic         r;
    logic [DW-1:0] d;
    bit           poke;
    logic         e_err;
    int unsigned  e_data;
    int unsigned  e_cnt;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input string name, input int s, input logic w, input logic r,
                              input int unsigned d, input bit poke, input logic e_err,
                              input int unsigned e_data, input int unsigned e_cnt);
    vec_t v;
    v.name = name; v.s = s; v.w = w; v.r = r; v.d = DW'(d); v.poke = poke;
    v.e_err = e_err; v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic ge, gd, gh;
  int   gl;

  initial begin
    wrt = '0; rd = '0; din[0] = '0; din[1] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      chk("reset ready", 32'(rdy[s]), 1);
      chk("reset count", 32'(cnt[s]), 0);
      chk("reset empty", 32'(empty[s]), 1);
      chk("reset full",  32'(full[s]), 0);
      chk("reset data",  32'(dout[s]), 0);
      chk("reset err",   32'(err[s]), 0);
    end

    // Directed vectors: name, dut, wrt, read, data, poke-while-busy, err, data, count
    tab.push_back(mk("enq5",      0, 1, 0,   5, 0, 0,   5, 1));
    tab.push_back(mk("enq900",    0, 1, 0, 900, 0, 0, 900, 2));
    tab.push_back(mk("enq17",     0, 1, 0,  17, 1, 0, 900, 3));
    tab.push_back(mk("enq300",    0, 1, 0, 300, 0, 0, 900, 4));
    tab.push_back(mk("enq900b",   0, 1, 0, 900, 0, 0, 900, 5));
    tab.push_back(mk("enq1",      0, 1, 0,   1, 1, 0, 900, 6));
    tab.push_back(mk("enq64",     0, 1, 0,  64, 0, 0, 900, 7));
    tab.push_back(mk("enq_full",  0, 1, 0,  42, 0, 1, 900, 7));
    tab.push_back(mk("deq1",      0, 0, 1,   0, 1, 0, 900, 6));
    tab.push_back(mk("deq2",      0, 0, 1,   0, 0, 0, 300, 5));
    tab.push_back(mk("deq3",      0, 0, 1,   0, 0, 0,  64, 4));
    tab.push_back(mk("deq4",      0, 0, 1,   0, 0, 0,  17, 3));
    tab.push_back(mk("deq5",      0, 0, 1,   0, 0, 0,   5, 2));
    tab.push_back(mk("deq6",      0, 0, 1,   0, 0, 0,   1, 1));
    tab.push_back(mk("deq7",      0, 0, 1,   0, 0, 0,   0, 0));
    tab.push_back(mk("deq_empty", 0, 0, 1,   0, 0, 1,   0, 0));
    tab.push_back(mk("enq10",     0, 1, 0,  10, 0, 0,  10, 1));
    tab.push_back(mk("enq20",     0, 1, 0,  20, 0, 0,  20, 2));
    tab.push_back(mk("enq30",     0, 1, 0,  30, 0, 0,  30, 3));
    tab.push_back(mk("rep5",      0, 1, 1,   5, 0, 0,  20, 3));
    tab.push_back(mk("deq_r1",    0, 0, 1,   0, 0, 0,  10, 2));
    tab.push_back(mk("deq_r2",    0, 0, 1,   0, 0, 0,   5, 1));
    tab.push_back(mk("deq_r3",    0, 0, 1,   0, 0, 0,   0, 0));
    tab.push_back(mk("rep_empty", 0, 1, 1,  77, 0, 0,  77, 1));
    tab.push_back(mk("deq_77",    0, 0, 1,   0, 0, 0,   0, 0));
    tab.push_back(mk("min_enq8",  1, 1, 0,   8, 0, 0,   8, 1));
    tab.push_back(mk("min_enq3",  1, 1, 0,   3, 0, 0,   3, 2));
    tab.push_back(mk("min_enq3b", 1, 1, 0,   3, 0, 0,   3, 3));
    tab.push_back(mk("min_enq9",  1, 1, 0,   9, 0, 0,   3, 4));
    tab.push_back(mk("min_deq1",  1, 0, 1,   0, 0, 0,   3, 3));
    tab.push_back(mk("min_deq2",  1, 0, 1,   0, 0, 0,   8, 2));
    tab.push_back(mk("min_deq3",  1, 0, 1,   0, 0, 0,   9, 1));
    tab.push_back(mk("min_deq4",  1, 0, 1,   0, 0, 0,   0, 0));

    foreach (tab[i]) begin
      run_op(tab[i].s, tab[i].w, tab[i].r, tab[i].d, tab[i].poke, ge, gl, gd, gh);
      check_op(tab[i].name, tab[i].s, tab[i].e_err, tab[i].e_data, tab[i].e_cnt, ge, gl, gd, gh);
    end

    // Reset while an enqueue of 100 is still sifting up through a 6-entry heap
    reset_pulse();
    for (int k = 1; k <= 6; k++) run_op(0, 1'b1, 1'b0, DW'(k), 1'b0, ge, gl, gd, gh);
    chk("midsift pre count", 32'(cnt[0]), 6);
    wrt[0] = 1'b1; din[0] = 16'd100;
    @(posedge clk);
    #1 wrt[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midsift busy", 32'(rdy[0]), 0);
    chk("midsift hold count", 32'(cnt[0]), 6);
    #1 rst_n = 1'b0;
    #1;
    chk("midsift rst count", 32'(cnt[0]), 0);
    chk("midsift rst empty", 32'(empty[0]), 1);
    chk("midsift rst data",  32'(dout[0]), 0);
    chk("midsift rst ready", 32'(rdy[0]), 1);
    chk("midsift rst full",  32'(full[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b1, 1'b0, 16'd11, 1'b0, ge, gl, gd, gh);
    check_op("post_reset_enq11", 0, 1'b0, 11, 1, ge, gl, gd, gh);

    // Random ops on each instance against the bag model
    for (int s = 0; s < 2; s++) begin
      reset_pulse();
      mq.delete();
      mmin = (s == 1);
      for (int i = 0; i < ((s == 0) ? 500 : 300); i++) begin
        int unsigned op;
        logic [DW-1:0] d;
        logic w, r, e_err;
        op = $urandom_range(0, 2);
        d  = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 40));
        w  = (op != 1);
        r  = (op != 0);
        e_err = (op == 0 && mq.size() == QS) || (op == 1 && mq.size() == 0);
        if (!e_err) begin
          if (r && mq.size() > 0) mq.delete(best_pos());
          if (w) mq.push_back(32'(d));
        end
        run_op(s, w, r, d, (i % 5) == 0, ge, gl, gd, gh);
        check_op($sformatf("rand%0d_%0d", s, i), s, e_err, model_root(), mq.size(), ge, gl, gd, gh);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
